cam_frame_profiler: RTL and testbench

- Parametrised successor to the single-probe pixel/row counter on the camera input path.
- Oversamples the camera interface (iPclk, iHref, iVsync, iPdata) on the system clock.
- Counts pixels per line and lines per frame, and captures one pixel at a runtime-programmable coordinate.
- Reports last-line length, last-frame line count, a frame counter, a new-frame pulse and a sticky overflow flag to the debug/LED logic.

---
 rtl/cam_frame_profiler.sv | 150 +++++++++++++++
 tb/tb_cam_frame_profiler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_profiler.sv
// rtl/cam_frame_profiler.sv - camera line/frame profiler with a programmable pixel probe
// Define CAM_INPUT_SYNC_EN to put 2-flop synchronisers in front of the sample stage.
module cam_frame_profiler #(
  parameter int DATA_W  = 8,
  parameter int PIX_W   = 12,
  parameter int LINE_W  = 10,
  parameter int FRAME_W = 8
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iEnable,
  input  logic               iVsync,
  input  logic               iHref,
  input  logic               iPclk,
  input  logic [DATA_W-1:0]  iPdata,
  input  logic [PIX_W-1:0]   iProbeX,
  input  logic [LINE_W-1:0]  iProbeY,
  output logic               oNewFrame,
  output logic [DATA_W-1:0]  oProbeData,
  output logic               oProbeValid,
  output logic [PIX_W-1:0]   oLineLength,
  output logic [LINE_W-1:0]  oFrameLines,
  output logic [FRAME_W-1:0] oFrameCount,
  output logic               oOverflow
);

  localparam logic [PIX_W-1:0]  PIX_MAX  = '1;
  localparam logic [LINE_W-1:0] LINE_MAX = '1;

  logic              rawVsync, rawHref, rawPclk;
  logic [DATA_W-1:0] rawData;

`ifdef CAM_INPUT_SYNC_EN
  logic [2:0]        syncA, syncB;
  logic [DATA_W-1:0] dataA, dataB;

  // Pixel data is delayed alongside the control synchronisers so it stays aligned with pclk.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      syncA <= '0;
      syncB <= '0;
      dataA <= '0;
      dataB <= '0;
    end else begin
      syncA <= {iVsync, iHref, iPclk};
      syncB <= syncA;
      dataA <= iPdata;
      dataB <= dataA;
    end
  end

  assign {rawVsync, rawHref, rawPclk} = syncB;
  assign rawData = dataB;
`else
  assign {rawVsync, rawHref, rawPclk} = {iVsync, iHref, iPclk};
  assign rawData = iPdata;
`endif

  logic              sVsync, sHref, sPclk;
  logic [DATA_W-1:0] sData;
  logic              pVsync, pHref, pPclk;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      sVsync <= 1'b0;
      sHref  <= 1'b0;
      sPclk  <= 1'b0;
      sData  <= '0;
      pVsync <= 1'b0;
      pHref  <= 1'b0;
      pPclk  <= 1'b0;
    end else if (iEnable) begin
      sVsync <= rawVsync;
      sHref  <= rawHref;
      sPclk  <= rawPclk;
      sData  <= rawData;
      pVsync <= sVsync;
      pHref  <= sHref;
      pPclk  <= sPclk;
    end
  end

  logic pclkRise, hrefRise, hrefFall, vsyncRise, pixEvent;

  assign pclkRise  = iEnable & sPclk & ~pPclk;
  assign hrefRise  = iEnable & sHref & ~pHref;
  assign hrefFall  = iEnable & ~sHref & pHref;
  assign vsyncRise = iEnable & sVsync & ~pVsync;
  assign pixEvent  = pclkRise & sHref;

  logic [PIX_W-1:0]  pixCnt, pixBase, pixNext;
  logic [LINE_W-1:0] lineCnt, lineDone, lineNext;
  logic              pixSat, lineSat, probeHit;

  // lineDone is the line count after any href fall this cycle, so a coincident vsync sees it.
  always_comb begin
    pixBase  = hrefRise ? '0 : pixCnt;
    pixNext  = pixBase;
    lineDone = lineCnt;
    pixSat   = 1'b0;
    lineSat  = 1'b0;
    probeHit = 1'b0;
    if (pixEvent) begin
      probeHit = (pixBase == iProbeX) && (lineCnt == iProbeY);
      if (pixBase == PIX_MAX) pixSat = 1'b1;
      else                    pixNext = pixBase + 1'b1;
    end
    if (hrefFall) begin
      pixNext = '0;
      if (lineCnt == LINE_MAX) lineSat = 1'b1;
      else                     lineDone = lineCnt + 1'b1;
    end
    lineNext = lineDone;
    if (vsyncRise) begin
      pixNext  = '0;
      lineNext = '0;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      pixCnt      <= '0;
      lineCnt     <= '0;
      oLineLength <= '0;
      oFrameLines <= '0;
      oFrameCount <= '0;
      oOverflow   <= 1'b0;
      oProbeData  <= '0;
      oNewFrame   <= 1'b0;
      oProbeValid <= 1'b0;
    end else begin
      oNewFrame   <= vsyncRise;
      oProbeValid <= probeHit;
      if (iEnable) begin
        pixCnt  <= pixNext;
        lineCnt <= lineNext;
        if (hrefFall) oLineLength <= pixCnt;
        if (probeHit) oProbeData <= sData;
        if (vsyncRise) begin
          oFrameLines <= lineDone;
          oFrameCount <= oFrameCount + 1'b1;
          oOverflow   <= pixSat | lineSat;
        end else begin
          oOverflow   <= oOverflow | pixSat | lineSat;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_profiler.sv
// tb/tb_cam_frame_profiler.sv - randomized self-checking bench for cam_frame_profiler
module tb_cam_frame_profiler;

  localparam int DATA_W   = 8;
  localparam int PIX_W    = 4;
  localparam int LINE_W   = 3;
  localparam int FRAME_W  = 2;
  localparam int PIX_MAX  = 15;
  localparam int LINE_MAX = 7;
`ifdef CAM_INPUT_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic               iClock  = 1'b0;
  logic               iReset  = 1'b1;
  logic               iEnable = 1'b0;
  logic               iVsync  = 1'b0;
  logic               iHref   = 1'b0;
  logic               iPclk   = 1'b0;
  logic [DATA_W-1:0]  iPdata  = '0;
  logic [PIX_W-1:0]   iProbeX = '0;
  logic [LINE_W-1:0]  iProbeY = '0;
  logic               oNewFrame;
  logic [DATA_W-1:0]  oProbeData;
  logic               oProbeValid;
  logic [PIX_W-1:0]   oLineLength;
  logic [LINE_W-1:0]  oFrameLines;
  logic [FRAME_W-1:0] oFrameCount;
  logic               oOverflow;

  cam_frame_profiler #(
    .DATA_W(DATA_W), .PIX_W(PIX_W), .LINE_W(LINE_W), .FRAME_W(FRAME_W)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable),
    .iVsync(iVsync), .iHref(iHref), .iPclk(iPclk), .iPdata(iPdata),
    .iProbeX(iProbeX), .iProbeY(iProbeY),
    .oNewFrame(oNewFrame), .oProbeData(oProbeData), .oProbeValid(oProbeValid),
    .oLineLength(oLineLength), .oFrameLines(oFrameLines),
    .oFrameCount(oFrameCount), .oOverflow(oOverflow)
  );

  always #5 iClock = ~iClock;

  int cycle = 0;
  always @(posedge iClock) cycle++;

  int nfCnt = 0, nfCycle = 0, pvCnt = 0, pvData = 0;
  always @(negedge iClock) begin
    if (oNewFrame) begin
      nfCnt++;
      nfCycle = cycle;
    end
    if (oProbeValid) begin
      pvCnt++;
      pvData = int'(oProbeData);
    end
  end

  int nChecks = 0, nPass = 0;
  task automatic checkEq(input string tag, input int got, input int exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: plain counts of what the bench has driven, clipped at the counter limits.
  int mPix = 0, mLine = 0, mFrames = 0, mOvf = 0, mLineLen = 0, mFrameLines = 0;
  int mProbeCnt = 0, mProbeData = 0, mNewFrames = 0, vCycle = 0;

  function automatic int minI(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic waitClk(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic pixel(input int d);
    iPclk = 1'b0;
    waitClk($urandom_range(2, 3));
    iPdata = d[7:0];
    iPclk  = 1'b1;
    if (minI(mPix, PIX_MAX) == int'(iProbeX) && minI(mLine, LINE_MAX) == int'(iProbeY)) begin
      mProbeCnt++;
      mProbeData = d & 255;
    end
    if (mPix >= PIX_MAX) mOvf = 1;
    mPix++;
    waitClk($urandom_range(2, 3));
    iPclk = 1'b0;
  endtask

  task automatic checkFrame();
    checkEq("frameLines", int'(oFrameLines), mFrameLines);
    checkEq("frameCount", int'(oFrameCount), mFrames % 4);
    checkEq("frameOverflow", int'(oOverflow), mOvf);
    checkEq("newFramePulses", nfCnt, mNewFrames);
    checkEq("newFrameLatency", nfCycle - vCycle, LAT);
    checkEq("probePulses", pvCnt, mProbeCnt);
    checkEq("probeData", pvData, mProbeData);
  endtask

  task automatic doVsync(input int satSame);
    mFrameLines = minI(mLine, LINE_MAX);
    mLine = 0;
    mPix = 0;
    mFrames++;
    mOvf = satSame;
    mNewFrames++;
    iVsync = 1'b1;
    vCycle = cycle;
    waitClk(6);
    iVsync = 1'b0;
    waitClk(4);
    checkFrame();
  endtask

  task automatic lineBegin();
    iHref = 1'b1;
    mPix = 0;
    waitClk(2);
  endtask

  task automatic linePixels(input int n, input bit directed);
    for (int i = 0; i < n; i++)
      pixel(directed ? (16 * mLine + i) : int'($urandom_range(0, 255)));
  endtask

  task automatic lineFinish(input bit withVsync);
    int satNow;
    waitClk(2);
    satNow = (mLine >= LINE_MAX) ? 1 : 0;
    mLineLen = minI(mPix, PIX_MAX);
    if (satNow != 0) mOvf = 1;
    mLine++;
    mPix = 0;
    iHref = 1'b0;
    if (withVsync) doVsync(satNow);
    else waitClk(6);
    checkEq("lineLength", int'(oLineLength), mLineLen);
    checkEq("lineOverflow", int'(oOverflow), mOvf);
  endtask

  task automatic sendLine(input int n, input bit directed, input bit withVsync);
    lineBegin();
    linePixels(n, directed);
    lineFinish(withVsync);
  endtask

  task automatic checkAllZero(input string tag);
    checkEq({tag, "_newFrame"}, int'(oNewFrame), 0);
    checkEq({tag, "_probeValid"}, int'(oProbeValid), 0);
    checkEq({tag, "_probeData"}, int'(oProbeData), 0);
    checkEq({tag, "_lineLength"}, int'(oLineLength), 0);
    checkEq({tag, "_frameLines"}, int'(oFrameLines), 0);
    checkEq({tag, "_frameCount"}, int'(oFrameCount), 0);
    checkEq({tag, "_overflow"}, int'(oOverflow), 0);
  endtask

  initial begin
    int nl;
    bit endV;
    #2 iReset = 1'b0;
    #1 checkAllZero("reset");
    waitClk(3);
    iReset  = 1'b1;
    waitClk(2);
    iEnable = 1'b1;
    waitClk(2);

    // 4 lines x 10 pixels, probe at (3,2), pdata = 16*line + pixel
    iProbeX = 4'd3;
    iProbeY = 3'd2;
    for (int l = 0; l < 4; l++) sendLine(10, 1'b1, 1'b0);
    doVsync(0);
    checkEq("probe23", pvData, 'h23);

    // four more frames walk the 2-bit frame counter through 2,3,0,1
    for (int k = 0; k < 4; k++) doVsync(0);

    // 20-pixel line saturates the pixel counter, vsync clears overflow
    sendLine(20, 1'b0, 1'b0);
    doVsync(0);

    // masked pclk edges and a masked vsync pulse must leave no trace
    iProbeX = 4'd4;
    iProbeY = 3'd0;
    lineBegin();
    linePixels(3, 1'b0);
    waitClk(6);
    iEnable = 1'b0;
    waitClk(2);
    for (int k = 0; k < 5; k++) begin
      iPclk = 1'b1;
      iPdata = 8'hEE;
      waitClk(2);
      iPclk = 1'b0;
      waitClk(2);
    end
    iVsync = 1'b1;
    waitClk(3);
    iVsync = 1'b0;
    waitClk(3);
    iEnable = 1'b1;
    waitClk(2);
    checkEq("maskedNewFrame", nfCnt, mNewFrames);
    checkEq("maskedProbe", pvCnt, mProbeCnt);
    linePixels(2, 1'b0);
    lineFinish(1'b0);

    // 3 more lines then href fall coincident with vsync: line counted first
    for (int l = 0; l < 2; l++) sendLine(4, 1'b0, 1'b0);
    sendLine(5, 1'b0, 1'b1);
    sendLine(3, 1'b0, 1'b0);
    doVsync(0);

    // 9 short lines saturate the line counter
    for (int l = 0; l < 9; l++) sendLine(2, 1'b0, 1'b0);
    doVsync(0);

    // randomized frames with random probe coordinates
    for (int f = 0; f < 6; f++) begin
      iProbeX = 4'($urandom_range(0, 15));
      iProbeY = 3'($urandom_range(0, 7));
      nl = $urandom_range(0, 9);
      endV = 1'b0;
      for (int l = 0; l < nl; l++) begin
        bit v;
        v = (l == nl - 1) && ($urandom_range(0, 1) == 1);
        sendLine($urandom_range(0, 18), 1'b0, v);
        endV = v;
      end
      if (!endV) doVsync(0);
    end

    // asynchronous reset in the middle of a line
    iProbeX = 4'd15;
    iProbeY = 3'd7;
    lineBegin();
    linePixels(9, 1'b0);
    waitClk(2);
    iReset = 1'b0;
    #1 checkAllZero("midReset");
    mPix = 0; mLine = 0; mFrames = 0; mOvf = 0; mLineLen = 0; mFrameLines = 0;
    iHref = 1'b0;
    waitClk(3);
    iReset = 1'b1;
    waitClk(3);
    sendLine(6, 1'b0, 1'b0);
    doVsync(0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d expected %0d", cycle, 0);
    $fatal(1);
  end

endmodule
